// File: rtl/dbus_arbiter.sv
// ---------------------------------------------------------------------------
// dbus_arbiter
//
// Shares the single 16-bit data port of the memory/IO subsystem between the
// CPU data port (C) and a DMA/debug master (D). Each cycle one requester is
// granted. The granted address is decoded to memory (addr >= MEMADDRBASE) or
// IO, byte write enables go only to the decoded target, and read data comes
// back one cycle later, steered by a registered target/owner select.
//
// Arbitration: OPEN state is round-robin between C and D. An accepted D
// transaction with d_lock=1 moves to LOCKED, where only D is granted. The
// lock ends when D stops requesting, when D completes a transaction with
// d_lock=0, or after MAX_LOCK locked cycles with C waiting. A forced release
// hands the next tie to C.
//
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   c_req/c_addr/c_wen/c_wdata   CPU request side;  c_gnt, c_rvalid outputs
//   d_req/d_lock/d_addr/d_wen/d_wdata  DMA request side; d_gnt, d_rvalid
//   rdata             shared read return data, qualified by c/d_rvalid
//   bus_addr/bus_wdata           address and write data to memory and IO
//   mem_dwrite_en/io_dwrite_en   per-target byte write enables
//   mem_dread_data/io_dread_data read data from the targets (1-cycle latency)
// ---------------------------------------------------------------------------
module dbus_arbiter #(
    parameter logic [15:0] MEMADDRBASE = 16'h2000,
    parameter int unsigned MAX_LOCK    = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        c_req,
    input  logic [15:0] c_addr,
    input  logic [1:0]  c_wen,
    input  logic [15:0] c_wdata,
    output logic        c_gnt,
    output logic        c_rvalid,
    input  logic        d_req,
    input  logic        d_lock,
    input  logic [15:0] d_addr,
    input  logic [1:0]  d_wen,
    input  logic [15:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [15:0] rdata,
    output logic [15:0] bus_addr,
    output logic [15:0] bus_wdata,
    output logic [1:0]  mem_dwrite_en,
    output logic [1:0]  io_dwrite_en,
    input  logic [15:0] mem_dread_data,
    input  logic [15:0] io_dread_data
);

    localparam int unsigned      CNT_W    = (MAX_LOCK > 1) ? $clog2(MAX_LOCK) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_LOCK - 1);

    typedef enum logic {
        ST_OPEN   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic             last_gnt_d_q, last_gnt_d_d;   // 1: D was granted last
    logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
    logic             rd_pend_q, rd_pend_d;
    logic             rd_owner_d_q, rd_owner_d_d;   // 1: pending read belongs to D
    logic             rd_mem_q, rd_mem_d;

    logic [1:0]       gnt_wen;
    logic             sel_mem;
    logic             accept;

    // Grant decision. Grants are combinational and forced low while reset
    // is held so nothing leaks out during an asynchronous reset.
    always_comb begin
        c_gnt = 1'b0;
        d_gnt = 1'b0;
        if (reset) begin
            if (state_q == ST_LOCKED) begin
                d_gnt = d_req;
            end else if (c_req && d_req) begin
                c_gnt = last_gnt_d_q;
                d_gnt = !last_gnt_d_q;
            end else begin
                c_gnt = c_req;
                d_gnt = d_req;
            end
        end
    end

    // Bus mux and target decode. With no grant the bus parks on the CPU side.
    always_comb begin
        bus_addr      = d_gnt ? d_addr  : c_addr;
        bus_wdata     = d_gnt ? d_wdata : c_wdata;
        gnt_wen       = d_gnt ? d_wen : (c_gnt ? c_wen : 2'b00);
        sel_mem       = (bus_addr >= MEMADDRBASE);
        mem_dwrite_en = sel_mem ? gnt_wen : 2'b00;
        io_dwrite_en  = sel_mem ? 2'b00 : gnt_wen;
        accept        = c_gnt || d_gnt;
    end

    // Lock state machine, round-robin pointer and read-return bookkeeping.
    always_comb begin
        state_d      = state_q;
        lock_cnt_d   = lock_cnt_q;
        last_gnt_d_d = last_gnt_d_q;

        if (c_gnt) last_gnt_d_d = 1'b0;
        if (d_gnt) last_gnt_d_d = 1'b1;

        case (state_q)
            ST_OPEN: begin
                if (d_gnt && d_lock) begin
                    state_d    = ST_LOCKED;
                    lock_cnt_d = '0;
                end
            end
            ST_LOCKED: begin
                // Counts only cycles in which C is kept waiting.
                if (c_req && (lock_cnt_q != CNT_LAST)) begin
                    lock_cnt_d = lock_cnt_q + 1'b1;
                end
                if (!d_req || (d_gnt && !d_lock)) begin
                    state_d = ST_OPEN;
                end else if (c_req && (lock_cnt_q == CNT_LAST)) begin
                    // Forced release: mark D as last so C takes the next tie.
                    state_d      = ST_OPEN;
                    last_gnt_d_d = 1'b1;
                end
            end
            default: state_d = ST_OPEN;
        endcase

        rd_pend_d    = accept && (gnt_wen == 2'b00);
        rd_owner_d_d = d_gnt;
        rd_mem_d     = sel_mem;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_OPEN;
            last_gnt_d_q <= 1'b1;
            lock_cnt_q   <= '0;
            rd_pend_q    <= 1'b0;
            rd_owner_d_q <= 1'b0;
            rd_mem_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_gnt_d_q <= last_gnt_d_d;
            lock_cnt_q   <= lock_cnt_d;
            rd_pend_q    <= rd_pend_d;
            rd_owner_d_q <= rd_owner_d_d;
            rd_mem_q     <= rd_mem_d;
        end
    end

    // Read return: one cycle after the accepted read.
    assign c_rvalid = rd_pend_q && !rd_owner_d_q;
    assign d_rvalid = rd_pend_q && rd_owner_d_q;
    assign rdata    = rd_mem_q ? mem_dread_data : io_dread_data;

endmodule

// File: tb/tb_dbus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dbus_arbiter
//
// Directed steps followed by a randomized phase. A behavioural model tracks
// whether D holds the bus, who won the last tie, how many cycles C has been
// kept waiting under the lock, and the one outstanding read.
// ---------------------------------------------------------------------------
module tb_dbus_arbiter;

    localparam int ML = 4;

    logic        clk;
    logic        reset;
    logic        c_req, d_req, d_lock;
    logic [15:0] c_addr, d_addr, c_wdata, d_wdata;
    logic [1:0]  c_wen, d_wen;
    logic        c_gnt, d_gnt, c_rvalid, d_rvalid;
    logic [15:0] rdata, bus_addr, bus_wdata;
    logic [1:0]  mem_dwrite_en, io_dwrite_en;
    logic [15:0] mem_dread_data, io_dread_data;

    dbus_arbiter #(
        .MEMADDRBASE (16'h2000),
        .MAX_LOCK    (ML)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .c_req          (c_req),
        .c_addr         (c_addr),
        .c_wen          (c_wen),
        .c_wdata        (c_wdata),
        .c_gnt          (c_gnt),
        .c_rvalid       (c_rvalid),
        .d_req          (d_req),
        .d_lock         (d_lock),
        .d_addr         (d_addr),
        .d_wen          (d_wen),
        .d_wdata        (d_wdata),
        .d_gnt          (d_gnt),
        .d_rvalid       (d_rvalid),
        .rdata          (rdata),
        .bus_addr       (bus_addr),
        .bus_wdata      (bus_wdata),
        .mem_dwrite_en  (mem_dwrite_en),
        .io_dwrite_en   (io_dwrite_en),
        .mem_dread_data (mem_dread_data),
        .io_dread_data  (io_dread_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    bit m_locked;
    bit m_last_d;
    int m_wait;        // locked cycles in which C was left waiting
    bit m_pend;
    bit m_pend_d;
    bit m_pend_mem;

    // Observed values captured at the mid-cycle check point
    logic        o_c_gnt, o_d_gnt, o_c_rv, o_d_rv;
    logic [1:0]  o_mem_en, o_io_en;
    logic [15:0] o_bus_addr, o_bus_wdata, o_rdata, o_mem_in, o_io_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: inputs are already driven (posedge+1); outputs are
    // checked at the falling edge, then the model advances at the rising edge.
    task automatic cycle();
        logic        ec, ed, emem;
        logic [15:0] ea, ewd;
        logic [1:0]  ew;
        mem_dread_data = 16'($urandom);
        io_dread_data  = 16'($urandom);
        #4;
        if (!reset) begin
            m_locked = 1'b0;
            m_last_d = 1'b1;
            m_wait   = 0;
            m_pend   = 1'b0;
        end
        ec = 1'b0;
        ed = 1'b0;
        if (reset) begin
            if (m_locked) begin
                ed = d_req;
            end else if (c_req && d_req) begin
                ec = m_last_d;
                ed = !m_last_d;
            end else begin
                ec = c_req;
                ed = d_req;
            end
        end
        ea   = ed ? d_addr : c_addr;
        ewd  = ed ? d_wdata : c_wdata;
        ew   = ed ? d_wen : (ec ? c_wen : 2'b00);
        emem = (ea >= 16'h2000);

        chk("c_gnt", c_gnt, ec);
        chk("d_gnt", d_gnt, ed);
        chk("bus_addr", bus_addr, ea);
        chk("bus_wdata", bus_wdata, ewd);
        chk("mem_dwrite_en", mem_dwrite_en, emem ? ew : 2'b00);
        chk("io_dwrite_en", io_dwrite_en, emem ? 2'b00 : ew);
        chk("c_rvalid", c_rvalid, m_pend && !m_pend_d);
        chk("d_rvalid", d_rvalid, m_pend && m_pend_d);
        if (m_pend) chk("rdata", rdata, m_pend_mem ? mem_dread_data : io_dread_data);

        o_c_gnt = c_gnt;   o_d_gnt = d_gnt;
        o_c_rv = c_rvalid; o_d_rv = d_rvalid;
        o_mem_en = mem_dwrite_en; o_io_en = io_dwrite_en;
        o_bus_addr = bus_addr; o_bus_wdata = bus_wdata; o_rdata = rdata;
        o_mem_in = mem_dread_data; o_io_in = io_dread_data;

        @(posedge clk);
        if (reset) begin
            m_pend     = (ec || ed) && (ew == 2'b00);
            m_pend_d   = ed;
            m_pend_mem = emem;
            if (ec) m_last_d = 1'b0;
            if (ed) m_last_d = 1'b1;
            if (!m_locked) begin
                if (ed && d_lock) begin
                    m_locked = 1'b1;
                    m_wait   = 0;
                end
            end else if (!d_req || (ed && !d_lock)) begin
                m_locked = 1'b0;
            end else if (c_req) begin
                m_wait++;
                if (m_wait >= ML) begin
                    m_locked = 1'b0;
                    m_last_d = 1'b1;
                end
            end
        end
        #1;
    endtask

    function automatic logic [15:0] rnd_addr();
        case ($urandom_range(0, 5))
            0:       return 16'h1FFF;
            1:       return 16'h2000;
            2:       return 16'hFFFF;
            3:       return 16'h0000;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        reset = 1'b0;
        c_req = 1'b0; d_req = 1'b0; d_lock = 1'b0;
        c_addr = 16'h0; d_addr = 16'h0; c_wdata = 16'h0; d_wdata = 16'h0;
        c_wen = 2'b00; d_wen = 2'b00;
        mem_dread_data = 16'h0; io_dread_data = 16'h0;
        @(posedge clk);
        #1;

        // Reset held: requests present, nothing granted, nothing enabled
        c_req = 1'b1; c_addr = 16'h2004; c_wen = 2'b11; d_req = 1'b1;
        cycle();
        chk("rst_c_gnt", o_c_gnt, 1'b0);
        chk("rst_d_gnt", o_d_gnt, 1'b0);
        chk("rst_mem_en", o_mem_en, 2'b00);
        chk("rst_c_rvalid", o_c_rv, 1'b0);
        reset = 1'b1;

        // C alone reads memory
        d_req = 1'b0; c_req = 1'b1; c_addr = 16'h2004; c_wen = 2'b00;
        cycle();
        chk("rd_c_gnt", o_c_gnt, 1'b1);
        chk("rd_bus_addr", o_bus_addr, 16'h2004);
        chk("rd_wen", {o_mem_en, o_io_en}, 4'b0000);
        c_req = 1'b0;
        cycle();
        chk("rd_c_rvalid", o_c_rv, 1'b1);
        chk("rd_rdata", o_rdata, o_mem_in);

        // C byte writes either side of the boundary
        c_req = 1'b1; c_addr = 16'h1FFE; c_wen = 2'b10; c_wdata = 16'hA55A;
        cycle();
        chk("wr_io_en", o_io_en, 2'b10);
        chk("wr_io_mem_en", o_mem_en, 2'b00);
        chk("wr_wdata", o_bus_wdata, 16'hA55A);
        c_addr = 16'h2000;
        cycle();
        chk("wr_mem_en", o_mem_en, 2'b10);
        chk("wr_mem_io_en", o_io_en, 2'b00);
        chk("wr_no_rvalid", o_c_rv, 1'b0);
        c_req = 1'b0;
        cycle();
        chk("wr_no_rvalid2", o_c_rv, 1'b0);

        // Fresh reset, then both request reads continuously: C, D, C, D ...
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        c_req = 1'b1; c_addr = 16'h2004; c_wen = 2'b00;
        d_req = 1'b1; d_addr = 16'h0100; d_wen = 2'b00; d_lock = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            chk("alt_c_gnt", o_c_gnt, (i % 2) == 0);
            chk("alt_d_gnt", o_d_gnt, (i % 2) == 1);
        end
        c_req = 1'b0; d_req = 1'b0;
        cycle();

        // D takes a lock, C waits: ML locked grants, then C
        d_req = 1'b1; d_lock = 1'b1;
        cycle();
        chk("lk_take", o_d_gnt, 1'b1);
        c_req = 1'b1;
        for (int i = 0; i < ML; i++) begin
            cycle();
            chk("lk_d_held", o_d_gnt, 1'b1);
            chk("lk_c_block", o_c_gnt, 1'b0);
        end
        cycle();
        chk("lk_forced_c", o_c_gnt, 1'b1);
        c_req = 1'b0; d_req = 1'b0;
        cycle();
        cycle();

        // Lock with C idle: lock persists and the wait count does not advance
        d_req = 1'b1; d_lock = 1'b1;
        cycle();
        chk("idle_take", o_d_gnt, 1'b1);
        for (int i = 0; i < 20; i++) cycle();
        chk("idle_d_held", o_d_gnt, 1'b1);
        c_req = 1'b1;
        for (int i = 0; i < ML - 1; i++) begin
            cycle();
            chk("idle_c_block", o_c_gnt, 1'b0);
        end
        d_lock = 1'b0;
        cycle();
        chk("unlock_d", o_d_gnt, 1'b1);
        cycle();
        chk("unlock_c_tie", o_c_gnt, 1'b1);
        c_req = 1'b0; d_req = 1'b0;
        cycle();

        // Read accepted, reset asserted in its return cycle
        c_req = 1'b1; c_addr = 16'h1000; c_wen = 2'b00;
        cycle();
        chk("rr_gnt", o_c_gnt, 1'b1);
        reset = 1'b0; c_wen = 2'b11; d_req = 1'b1;
        cycle();
        chk("rr_no_c_rv", o_c_rv, 1'b0);
        chk("rr_no_gnt", {o_c_gnt, o_d_gnt}, 2'b00);
        chk("rr_no_wen", {o_mem_en, o_io_en}, 4'b0000);
        reset = 1'b1; c_wen = 2'b00;
        cycle();
        chk("rr_c_first", o_c_gnt, 1'b1);
        cycle();

        // Randomized traffic; requesters hold their transaction until granted
        for (int i = 0; i < 600; i++) begin
            if (!(c_req && !o_c_gnt)) begin
                c_req   = ($urandom_range(0, 3) != 0);
                c_addr  = rnd_addr();
                c_wen   = 2'($urandom);
                c_wdata = 16'($urandom);
            end
            if (!(d_req && !o_d_gnt)) begin
                d_req   = ($urandom_range(0, 3) != 0);
                d_addr  = rnd_addr();
                d_wen   = 2'($urandom);
                d_wdata = 16'($urandom);
            end
            d_lock = ($urandom_range(0, 2) != 0);
            reset  = ($urandom_range(0, 79) != 0);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
